dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single data-memory port (MemArray port 1 plus the memory-mapped I/O decode behind it) between two requesters.
- Requester 0 is the processor load/store path.
- Requester 1 is a secondary master, such as a debug loader or DMA engine.
- Issues at most one access per cycle and returns read data one cycle later.
- Round-robin with a bounded burst length, so neither side starves the other.
- Sits between the requesters and the memory/I/O address decode.

Parameters:
DBITS, 16, data width of each word.
ABITS, 16, byte-address width. Passed through unmodified; the memory takes ADDR[12:1].
MAXBURST, 4, maximum consecutive grants one requester may hold while the other is requesting. Legal range 1..15.

Ports:
CLK  input  1  clock; all state updates on posedge.
RESET_N  input  1  synchronous reset, active-low.
REQ0  input  1  requester 0 access request.
WE0  input  1  requester 0 write (1) / read (0).
ADDR0  input  ABITS  requester 0 byte address.
WDATA0  input  DBITS  requester 0 write data.
GNT0  output  1  requester 0 access accepted this cycle.
STALL0  output  1  REQ0 & ~GNT0; used to hold the processor PC.
RVALID0  output  1  RDATA0 valid (read granted in the previous cycle).
RDATA0  output  DBITS  read data for requester 0.
REQ1, WE1, ADDR1, WDATA1, GNT1, STALL1, RVALID1, RDATA1: same as above, for requester 1.
MEM_ADDR  output  ABITS  address to memory/I/O decode.
MEM_DIN  output  DBITS  write data to memory.
MEM_WE  output  1  write enable to memory.
MEM_DOUT  input  DBITS  memory read data, valid one cycle after the address.

Behaviour:
- An access is transferred at a posedge where REQn=1 and GNTn=1. Requesters hold REQn, WEn, ADDRn and WDATAn stable until granted.
- GNTn is combinational from REQ0, REQ1, OWNER and CNT. GNT0 and GNT1 are never both 1.
- State registers:
  - OWNER (1 bit): last-granted requester.
  - CNT (4 bits): consecutive grants to OWNER while the other requester was waiting.
- Arbitration each cycle:
  - No requests: no grant. CNT <= 0. OWNER unchanged.
  - Only REQn: grant n. OWNER <= n. CNT <= 0.
  - Both requesting, CNT < MAXBURST: grant OWNER. CNT <= CNT+1.
  - Both requesting, CNT == MAXBURST: grant the other requester. OWNER <= other. CNT <= 1.
- Memory muxing (combinational):
  - MEM_ADDR and MEM_DIN come from the granted requester. With no grant they come from requester 0.
  - MEM_WE = (GNT0 & WE0) | (GNT1 & WE1). MEM_WE is never 1 without a grant.
- Read return:
  - RVALIDn <= GNTn & REQn & ~WEn, registered.
  - RDATAn = MEM_DOUT, combinationally routed, and qualified by RVALIDn. RDATAn is undefined when RVALIDn=0.
  - Read latency is exactly 1 cycle from the grant.
- Write completes at the granted posedge; no response is returned.
- Back-to-back grants to the same or alternating requesters are allowed every cycle. There are no bubbles.
- Reset (RESET_N=0 at a posedge):
  - OWNER <= 0, CNT <= 0, RVALID0 <= 0, RVALID1 <= 0.
  - While RESET_N=0: GNT0=GNT1=0, MEM_WE=0, STALL0=REQ0, STALL1=REQ1.
  - Reset mid-operation drops an in-flight read: RVALID is not asserted after reset.
- First cycle after reset with both requesting: requester 0 wins (OWNER=0, CNT=0).
- MAXBURST=1 gives strict alternation under contention.

Test Plan:
1. Reset, then REQ0=1, WE0=0, ADDR0=16'h0010 for one cycle; MEM_DOUT=16'h1234 the next cycle -> GNT0=1, MEM_ADDR=16'h0010, MEM_WE=0; next cycle RVALID0=1 with RDATA0=16'h1234; RVALID1=0 throughout.
2. REQ1=1, WE1=1, ADDR1=16'hFFF8, WDATA1=16'hBEEF, REQ0=0 -> GNT1=1, MEM_WE=1, MEM_ADDR=16'hFFF8, MEM_DIN=16'hBEEF; RVALID1 stays 0.
3. MAXBURST=4, REQ0 and REQ1 both held high 12 cycles from reset -> grant sequence 0,0,0,0,1,1,1,1,0,0,0,0; STALL is high on the non-granted side each cycle.
4. MAXBURST=4, both requesting, REQ1 drops after 2 grants to requester 1 -> requester 0 granted the next cycle; CNT restarts, so requester 0 then holds up to 4 grants once REQ1 returns.
5. Read granted to requester 0 at cycle N, RESET_N=0 at cycle N+1 -> RVALID0=0 at N+1 and N+2; GNT0=GNT1=0 and MEM_WE=0 while reset is low.
6. MAXBURST=1, both requesting continuously, alternating WE patterns -> grants alternate 0,1,0,1...; MEM_WE matches the granted side's WE each cycle; RVALIDn follows only the granted reads.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port (and the memory-mapped I/O decode behind
// it) between two requesters: requester 0 is the processor load/store path,
// requester 1 is a secondary master (debug loader, DMA). At most one access is
// issued per cycle; read data returns exactly one cycle after the grant.
// Contention is resolved round-robin with a bounded burst: the current owner
// keeps the port for up to MAXBURST consecutive grants while the other side
// waits, then ownership passes across.
//
// Ports
//   CLK, RESET_N          clock; synchronous active-low reset
//   REQn, WEn             access request / write(1) read(0), n = 0, 1
//   ADDRn, WDATAn         byte address / write data, held until granted
//   GNTn                  access accepted this cycle (combinational)
//   STALLn                REQn & ~GNTn, holds the requester (e.g. the PC)
//   RVALIDn, RDATAn       read response, one cycle after a granted read
//   MEM_ADDR, MEM_DIN     address / write data towards memory and I/O decode
//   MEM_WE                write strobe towards memory, only with a grant
//   MEM_DOUT              memory read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned DBITS    = 16,
    parameter int unsigned ABITS    = 16,
    parameter int unsigned MAXBURST = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,

    input  logic             REQ0,
    input  logic             WE0,
    input  logic [ABITS-1:0] ADDR0,
    input  logic [DBITS-1:0] WDATA0,
    output logic             GNT0,
    output logic             STALL0,
    output logic             RVALID0,
    output logic [DBITS-1:0] RDATA0,

    input  logic             REQ1,
    input  logic             WE1,
    input  logic [ABITS-1:0] ADDR1,
    input  logic [DBITS-1:0] WDATA1,
    output logic             GNT1,
    output logic             STALL1,
    output logic             RVALID1,
    output logic [DBITS-1:0] RDATA1,

    output logic [ABITS-1:0] MEM_ADDR,
    output logic [DBITS-1:0] MEM_DIN,
    output logic             MEM_WE,
    input  logic [DBITS-1:0] MEM_DOUT
);

    // The burst counter is 4 bits wide, so the limit must fit in 1..15.
    if (MAXBURST < 1 || MAXBURST > 15) begin : g_bad_maxburst
        $error("dmem_arbiter: MAXBURST must be in 1..15");
    end

    localparam logic [3:0] MaxCnt = 4'(MAXBURST);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic       owner_q, owner_d;     // last-granted requester
    logic [3:0] cnt_q, cnt_d;         // grants to owner while the other waited
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;

    // Combinational arbitration results
    logic       both_req;
    logic       burst_done;
    logic       winner;               // requester that wins under contention
    logic       gnt0, gnt1;

    assign both_req   = REQ0 & REQ1;
    assign burst_done = (cnt_q >= MaxCnt);
    assign winner     = burst_done ? ~owner_q : owner_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            owner_q   <= 1'b0;
            cnt_q     <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // -----------------------------------------------------------------------
    // Grant decision. Reset holds both grants low so nothing reaches memory
    // while the arbiter state is being cleared.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RESET_N) begin
            case ({REQ1, REQ0})
                2'b01: gnt0 = 1'b1;
                2'b10: gnt1 = 1'b1;
                2'b11: begin
                    gnt0 = ~winner;
                    gnt1 = winner;
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case ({REQ1, REQ0})
            2'b01: begin
                owner_d = 1'b0;
                cnt_d   = 4'd0;
            end
            2'b10: begin
                owner_d = 1'b1;
                cnt_d   = 4'd0;
            end
            2'b11: begin
                if (burst_done) begin
                    // Hand over; the new owner's first grant counts as one.
                    owner_d = ~owner_q;
                    cnt_d   = 4'd1;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
            end
        endcase

        rvalid0_d = gnt0 & REQ0 & ~WE0;
        rvalid1_d = gnt1 & REQ1 & ~WE1;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        GNT0   = gnt0;
        GNT1   = gnt1;
        STALL0 = REQ0 & ~gnt0;
        STALL1 = REQ1 & ~gnt1;

        // Requester 0 drives the memory bus by default when idle.
        if (gnt1) begin
            MEM_ADDR = ADDR1;
            MEM_DIN  = WDATA1;
        end else begin
            MEM_ADDR = ADDR0;
            MEM_DIN  = WDATA0;
        end
        MEM_WE = (gnt0 & WE0) | (gnt1 & WE1);

        // Masking with RESET_N drops a read that was in flight when reset hit,
        // even in the cycle before the registers are cleared.
        RVALID0 = rvalid0_q & RESET_N;
        RVALID1 = rvalid1_q & RESET_N;
        RDATA0  = RVALID0 ? MEM_DOUT : '0;
        RDATA1  = RVALID1 ? MEM_DOUT : '0;
    end

    // Never grant both sides in the same cycle.
    always_comb begin
        assert (!(gnt0 && gnt1));
    end

endmodule
